// File: rtl/control_fsm_tl_pkg.sv
// Shared transaction-layer control constants: one-hot state encodings and
// FIFO threshold defaults used by the control FSM, arbiter and FIFO bank.
package tl_ctrl_pkg;

  localparam int FIFO_DEPTH = 8;
  localparam int ALTO_DEF   = 6;
  localparam int BAJO_DEF   = 2;

  localparam logic [4:0] ST_RESET  = 5'b00001;
  localparam logic [4:0] ST_INIT   = 5'b00010;
  localparam logic [4:0] ST_IDLE   = 5'b00100;
  localparam logic [4:0] ST_ACTIVE = 5'b01000;
  localparam logic [4:0] ST_ERROR  = 5'b10000;

endpackage

// File: rtl/control_fsm_tl.sv
// Transaction-layer main control FSM: captures/validates FIFO thresholds in
// INIT, then tracks FIFO empties and error flags across IDLE/ACTIVE/ERROR.
module control_fsm_tl #(
  parameter int FIFO_DEPTH = tl_ctrl_pkg::FIFO_DEPTH,
  parameter int AW         = 4,
  parameter int ALTO_DEF   = tl_ctrl_pkg::ALTO_DEF,
  parameter int BAJO_DEF   = tl_ctrl_pkg::BAJO_DEF
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          init,
  input  logic [AW-1:0] umbral_alto_in,
  input  logic [AW-1:0] umbral_bajo_in,
  input  logic [7:0]    empties,
  input  logic [7:0]    fifo_error,
  output logic [4:0]    state,
  output logic [AW-1:0] umbral_alto,
  output logic [AW-1:0] umbral_bajo,
  output logic          idle,
  output logic          error_out,
  output logic          cfg_invalid
);
  import tl_ctrl_pkg::ST_RESET;
  import tl_ctrl_pkg::ST_INIT;
  import tl_ctrl_pkg::ST_IDLE;
  import tl_ctrl_pkg::ST_ACTIVE;
  import tl_ctrl_pkg::ST_ERROR;

  localparam logic [AW-1:0] DEPTH_AW = AW'(FIFO_DEPTH);
  localparam logic [AW-1:0] ALTO_AW  = AW'(ALTO_DEF);
  localparam logic [AW-1:0] BAJO_AW  = AW'(BAJO_DEF);

  logic [4:0]    state_nxt;
  logic [AW-1:0] alto_nxt;
  logic [AW-1:0] bajo_nxt;
  logic          cfg_invalid_nxt;
  logic          req_valid;

  always_comb begin
    req_valid       = (umbral_bajo_in < umbral_alto_in) &&
                      (umbral_alto_in <= DEPTH_AW);
    state_nxt       = ST_RESET;
    alto_nxt        = umbral_alto;
    bajo_nxt        = umbral_bajo;
    cfg_invalid_nxt = 1'b0;
    case (state)
      ST_RESET: state_nxt = ST_INIT;
      ST_INIT: begin
        cfg_invalid_nxt = !req_valid;
        if (req_valid) begin
          alto_nxt = umbral_alto_in;
          bajo_nxt = umbral_bajo_in;
        end
        if (!init && req_valid) begin
          state_nxt       = ST_IDLE;
          cfg_invalid_nxt = 1'b0;
        end else begin
          state_nxt = ST_INIT;
        end
      end
      ST_IDLE, ST_ACTIVE: begin
        // Error beats a configuration request, which beats the empties check
        if (fifo_error != 8'h00)   state_nxt = ST_ERROR;
        else if (init)             state_nxt = ST_INIT;
        else if (empties == 8'hFF) state_nxt = ST_IDLE;
        else                       state_nxt = ST_ACTIVE;
      end
      ST_ERROR: state_nxt = ST_ERROR;
      default:  state_nxt = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state       <= ST_RESET;
      umbral_alto <= ALTO_AW;
      umbral_bajo <= BAJO_AW;
      idle        <= 1'b0;
      error_out   <= 1'b0;
      cfg_invalid <= 1'b0;
    end else begin
      state       <= state_nxt;
      umbral_alto <= alto_nxt;
      umbral_bajo <= bajo_nxt;
      idle        <= (state_nxt == ST_IDLE);
      error_out   <= (state_nxt == ST_ERROR);
      cfg_invalid <= cfg_invalid_nxt;
    end
  end

endmodule

// File: tb/tb_control_fsm_tl.sv
// Directed bench for control_fsm_tl: linear stimulus with hand-computed
// expectations checked by immediate assertions after each clock edge.
module tb_control_fsm_tl;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       init;
  logic [3:0] umbral_alto_in;
  logic [3:0] umbral_bajo_in;
  logic [7:0] empties;
  logic [7:0] fifo_error;
  logic [4:0] state;
  logic [3:0] umbral_alto;
  logic [3:0] umbral_bajo;
  logic       idle;
  logic       error_out;
  logic       cfg_invalid;

  int compared   = 0;
  int mismatched = 0;

  control_fsm_tl dut (
    .clk            (clk),
    .reset_L        (reset_L),
    .init           (init),
    .umbral_alto_in (umbral_alto_in),
    .umbral_bajo_in (umbral_bajo_in),
    .empties        (empties),
    .fifo_error     (fifo_error),
    .state          (state),
    .umbral_alto    (umbral_alto),
    .umbral_bajo    (umbral_bajo),
    .idle           (idle),
    .error_out      (error_out),
    .cfg_invalid    (cfg_invalid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [4:0] st, input logic [3:0] alto,
                         input logic [3:0] bajo, input logic id, input logic er,
                         input logic ci);
    chk({tag, ".state"}, {3'b0, state}, {3'b0, st});
    chk({tag, ".alto"}, {4'b0, umbral_alto}, {4'b0, alto});
    chk({tag, ".bajo"}, {4'b0, umbral_bajo}, {4'b0, bajo});
    chk({tag, ".idle"}, {7'b0, idle}, {7'b0, id});
    chk({tag, ".error_out"}, {7'b0, error_out}, {7'b0, er});
    chk({tag, ".cfg_invalid"}, {7'b0, cfg_invalid}, {7'b0, ci});
  endtask

  initial begin
    reset_L = 1'b0; init = 1'b0; umbral_alto_in = 4'd0; umbral_bajo_in = 4'd0;
    empties = 8'hFF; fifo_error = 8'h00;

    // 1: reset held two edges, then release
    step(); step();
    chk_all("rst", 5'b00001, 4'd6, 4'd2, 1'b0, 1'b0, 1'b0);
    reset_L = 1'b1; init = 1'b1; umbral_alto_in = 4'd5; umbral_bajo_in = 4'd1;
    step();
    chk_all("rel", 5'b00010, 4'd6, 4'd2, 1'b0, 1'b0, 1'b0);

    // 2: valid request captured while init held, exit once init drops
    step();
    chk_all("init_hold", 5'b00010, 4'd5, 4'd1, 1'b0, 1'b0, 1'b0);
    init = 1'b0;
    step();
    chk_all("to_idle", 5'b00100, 4'd5, 4'd1, 1'b1, 1'b0, 1'b0);

    // 3: back to INIT, invalid equal thresholds, then fix
    init = 1'b1;
    step();
    chk_all("reinit", 5'b00010, 4'd5, 4'd1, 1'b0, 1'b0, 1'b0);
    init = 1'b0; umbral_alto_in = 4'd3; umbral_bajo_in = 4'd3;
    step();
    chk_all("inv_eq", 5'b00010, 4'd5, 4'd1, 1'b0, 1'b0, 1'b1);
    umbral_bajo_in = 4'd1;
    step();
    chk_all("fixed", 5'b00100, 4'd3, 4'd1, 1'b1, 1'b0, 1'b0);

    // 4: IDLE/ACTIVE on empties, init from ACTIVE
    empties = 8'hFE;
    step();
    chk_all("active", 5'b01000, 4'd3, 4'd1, 1'b0, 1'b0, 1'b0);
    empties = 8'hFF;
    step();
    chk_all("idle_again", 5'b00100, 4'd3, 4'd1, 1'b1, 1'b0, 1'b0);
    empties = 8'h7F;
    step();
    chk("active2.state", {3'b0, state}, 8'h08);
    init = 1'b1; umbral_alto_in = 4'd5; umbral_bajo_in = 4'd1;
    step();
    chk_all("act_init", 5'b00010, 4'd3, 4'd1, 1'b0, 1'b0, 1'b0);
    init = 1'b0;
    step();
    chk_all("idle3", 5'b00100, 4'd5, 4'd1, 1'b1, 1'b0, 1'b0);
    empties = 8'hFE;
    step();
    chk("active3.state", {3'b0, state}, 8'h08);

    // 5: error beats init, sticky, only reset leaves
    fifo_error = 8'h04; init = 1'b1;
    step();
    chk_all("err", 5'b10000, 4'd5, 4'd1, 1'b0, 1'b1, 1'b0);
    fifo_error = 8'h00; empties = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("err_sticky", 5'b10000, 4'd5, 4'd1, 1'b0, 1'b1, 1'b0);
    end
    reset_L = 1'b0;
    step();
    chk_all("err_rst", 5'b00001, 4'd6, 4'd2, 1'b0, 1'b0, 1'b0);

    // Boundaries: alto above depth invalid (fifo_error ignored), alto == depth valid
    reset_L = 1'b1; init = 1'b0; umbral_alto_in = 4'd9; umbral_bajo_in = 4'd1;
    step();
    chk("rel2.state", {3'b0, state}, 8'h02);
    fifo_error = 8'hFF;
    step();
    chk_all("inv_deep", 5'b00010, 4'd6, 4'd2, 1'b0, 1'b0, 1'b1);
    fifo_error = 8'h00; umbral_alto_in = 4'd8; umbral_bajo_in = 4'd7;
    step();
    chk_all("depth_ok", 5'b00100, 4'd8, 4'd7, 1'b1, 1'b0, 1'b0);

    // 6: reset from ACTIVE restores defaults
    init = 1'b1; umbral_alto_in = 4'd5; umbral_bajo_in = 4'd1;
    step();
    init = 1'b0;
    step();
    chk_all("idle6", 5'b00100, 4'd5, 4'd1, 1'b1, 1'b0, 1'b0);
    empties = 8'hEF;
    step();
    chk("active6.state", {3'b0, state}, 8'h08);
    reset_L = 1'b0;
    step();
    chk_all("act_rst", 5'b00001, 4'd6, 4'd2, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/control_fsm_tl.md
Name: control_fsm_tl

Overview:
Main control state machine of the transaction layer. Sits directly upstream of the arbiter and FIFO bank, and sources the one-hot `state` word the arbiter consumes. In INIT it captures and validates the FIFO almost-full/almost-empty thresholds, then distributes them. In operation it tracks the FIFO empties and error flags to move between IDLE, ACTIVE and ERROR.

Parameters:
FIFO_DEPTH, 8, entries per FIFO; upper bound for thresholds.
AW, 4, threshold width; must hold the value FIFO_DEPTH.
ALTO_DEF, 6, reset value of the almost-full threshold.
BAJO_DEF, 2, reset value of the almost-empty threshold.

Ports:
clk  in  1  single clock; all logic on posedge.
reset_L  in  1  synchronous reset, active-low.
init  in  1  request to (re)enter configuration.
umbral_alto_in  in  AW  almost-full threshold requested during INIT.
umbral_bajo_in  in  AW  almost-empty threshold requested during INIT.
empties  in  8  [3:0] naranja empties, [7:4] morado empties.
fifo_error  in  8  per-FIFO overflow/underflow flags, same bit order as empties.
state  out  5  one-hot: RESET=00001, INIT=00010, IDLE=00100, ACTIVE=01000, ERROR=10000. The arbiter uses state[3:0].
umbral_alto  out  AW  registered almost-full threshold to all FIFOs.
umbral_bajo  out  AW  registered almost-empty threshold to all FIFOs.
idle  out  1  high exactly while state==IDLE.
error_out  out  1  high exactly while state==ERROR.
cfg_invalid  out  1  high while in INIT with invalid requested thresholds.

Behaviour:
- Every output is registered; nothing is combinational from inputs.
- Reset. reset_L sampled low at a posedge, in any state including mid-ACTIVE or ERROR, gives at that edge:
  - state=RESET
  - umbral_alto=ALTO_DEF, umbral_bajo=BAJO_DEF
  - idle=0, error_out=0, cfg_invalid=0
- Latency. Inputs sampled at edge N drive state and flags at edge N. They are visible in the cycle after edge N, with no extra pipeline.
- RESET: first edge with reset_L=1 goes to INIT.
- INIT:
  - Request is valid when umbral_bajo_in < umbral_alto_in and umbral_alto_in <= FIFO_DEPTH.
  - Each edge in INIT: cfg_invalid <= !valid. If valid, umbral_alto/umbral_bajo <= request; if invalid, the registers hold.
  - Exit to IDLE when init==0 and the request is valid. Otherwise stay in INIT.
  - fifo_error is ignored in INIT.
- IDLE and ACTIVE transitions, first match wins:
  1. fifo_error!=0 goes to ERROR.
  2. init==1 goes to INIT.
  3. empties==8'hFF goes to IDLE.
  4. Otherwise go to ACTIVE.
- Thresholds are frozen outside INIT.
- ERROR is sticky. It ignores init, empties and fifo_error, and only reset_L=0 leaves it.
- cfg_invalid is forced to 0 on any transition out of INIT.
- No illegal-state lockup: any non-one-hot state register value goes to RESET on the next edge.

Decomposition:
- Package tl_ctrl_pkg holds:
  - state localparams ST_RESET, ST_INIT, ST_IDLE, ST_ACTIVE, ST_ERROR
  - default thresholds ALTO_DEF, BAJO_DEF and FIFO_DEPTH
- The package is shared with the arbiter and FIFO blocks.
- No sub-module: validity check and next-state logic live in one combinational block, beside one sequential block.

Test Plan:
1. reset_L=0 for 2 edges, then 1 → during reset state=00001, umbral_alto=6, umbral_bajo=2, idle=0, error_out=0; first edge after release state=00010.
2. INIT, init=1, alto_in=5, bajo_in=1; then init=0 → next edge state=00100, umbral_alto=5, umbral_bajo=1, idle=1, cfg_invalid=0.
3. INIT, alto_in=3, bajo_in=3, init=0 → state stays 00010, cfg_invalid=1, thresholds unchanged; then bajo_in=1 → next edge state=00100, umbral_bajo=1.
4. IDLE, empties=8'hFE → next edge state=01000, idle=0; then empties=8'hFF → state=00100, idle=1. Also drive init=1 in ACTIVE → state=00010.
5. ACTIVE, fifo_error=8'h04 with init=1 in the same cycle → state=10000, error_out=1. Then init=1 and empties=8'hFF for 3 edges → state stays 10000. Then reset_L=0 → state=00001, error_out=0.
6. ACTIVE after thresholds were set to 5/1; reset_L=0 for one edge → state=00001, umbral_alto=6, umbral_bajo=2.
